// File: rtl/isqrt_check_pipe.sv
// -----------------------------------------------------------------------------
// isqrt_check_pipe
//
// Pipelined checker for the inverse direction of an integer square root.
// Takes a radicand x and a claimed root y, and reports whether
// y == floor(sqrt(x)), which is equivalent to y*y <= x < (y+1)^2.
// It accepts one pair per clock with a fixed latency of 3 cycles. It keeps
// saturating check/error statistics and captures the first failing pair.
//
// Parameters
//   W        width of x and y (y is full width; any y >= 2^(W/2) fails)
//   CNT_W    width of the saturating check and error counters
//
// Ports
//   clk       in   1      clock, all state on rising edge
//   rst       in   1      asynchronous, active-low reset
//   arg_vld   in   1      x/y pair valid this cycle
//   x         in   W      radicand
//   y         in   W      claimed integer square root
//   clr       in   1      synchronous clear of counters and capture
//   res_vld   out  1      result valid, 3 cycles after arg_vld
//   res_ok    out  1      1: y*y <= x < (y+1)^2 (meaningful with res_vld)
//   chk_cnt   out  CNT_W  checked pairs, saturating
//   err_cnt   out  CNT_W  failed pairs, saturating
//   err_seen  out  1      sticky failure flag since reset/clr
//   err_x     out  W      x of the first failure since reset/clr
//   err_y     out  W      y of the first failure since reset/clr
// -----------------------------------------------------------------------------
module isqrt_check_pipe #(
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_vld,
  input  logic [W-1:0]     x,
  input  logic [W-1:0]     y,
  input  logic             clr,
  output logic             res_vld,
  output logic             res_ok,
  output logic [CNT_W-1:0] chk_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_seen,
  output logic [W-1:0]     err_x,
  output logic [W-1:0]     err_y
);

  localparam int                 PW      = 2 * W + 1;
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  // ---------------------------------------------------------------------------
  // Stage 1: capture the pair
  // ---------------------------------------------------------------------------
  logic         s1_vld;
  logic [W-1:0] s1_x;
  logic [W-1:0] s1_y;

  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge value of its inputs; blocking (=) here would make stage order
  // depend on statement order and collapse the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= arg_vld;
    end
  end

  // Data registers only toggle for valid pairs, so idle random bus activity
  // costs no switching power downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_x <= '0;
      s1_y <= '0;
    end else if (arg_vld) begin
      s1_x <= x;
      s1_y <= y;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: square the claimed root and form (y+1)^2
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] sq_c;
  logic [PW-1:0]  p_c;
  logic [2*W-1:0] s1_y_ext;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    s1_y_ext = '0;
    sq_c     = '0;
    p_c      = '0;
    s1_y_ext = {{W{1'b0}}, s1_y};
    // y < 2^W, so y*y fits exactly in 2W bits.
    sq_c     = s1_y_ext * s1_y_ext;
    // (y+1)^2 = y^2 + 2y + 1 needs one extra bit when y = 2^W-1.
    p_c      = {1'b0, sq_c} + {{W{1'b0}}, s1_y, 1'b0} + PW'(1);
  end

  logic           s2_vld;
  logic [W-1:0]   s2_x;
  logic [W-1:0]   s2_y;
  logic [2*W-1:0] s2_sq;
  logic [PW-1:0]  s2_p;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_vld <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
    end
  end

  // y rides along solely so a failing pair can be captured at the end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_x  <= '0;
      s2_y  <= '0;
      s2_sq <= '0;
      s2_p  <= '0;
    end else if (s1_vld) begin
      s2_x  <= s1_x;
      s2_y  <= s1_y;
      s2_sq <= sq_c;
      s2_p  <= p_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: bracket x between y^2 and (y+1)^2 (unsigned, 2W+1 bits)
  // ---------------------------------------------------------------------------
  logic         ok_c;
  logic [PW-1:0] x_ext;

  always_comb begin
    x_ext = '0;
    ok_c  = 1'b0;
    x_ext = {{(W+1){1'b0}}, s2_x};
    ok_c  = ({1'b0, s2_sq} <= x_ext) && (s2_p > x_ext);
  end

  logic [W-1:0] s3_x;
  logic [W-1:0] s3_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_vld <= 1'b0;
    end else begin
      res_vld <= s2_vld;
    end
  end

  // res_ok keeps its last value on idle cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_ok <= 1'b0;
      s3_x   <= '0;
      s3_y   <= '0;
    end else if (s2_vld) begin
      res_ok <= ok_c;
      s3_x   <= s2_x;
      s3_y   <= s2_y;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics: updated one cycle after each result, from registered outputs
  // so the compare logic does not also feed the counter adders.
  // clr wins over a coinciding update, which is then simply not counted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chk_cnt  <= '0;
      err_cnt  <= '0;
      err_seen <= 1'b0;
      err_x    <= '0;
      err_y    <= '0;
    end else if (clr) begin
      chk_cnt  <= '0;
      err_cnt  <= '0;
      err_seen <= 1'b0;
      err_x    <= '0;
      err_y    <= '0;
    end else if (res_vld) begin
      if (chk_cnt != CNT_MAX) begin
        chk_cnt <= chk_cnt + CNT_W'(1);
      end
      if (!res_ok) begin
        if (err_cnt != CNT_MAX) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        // Only the first failure is kept; later ones never overwrite it.
        if (!err_seen) begin
          err_seen <= 1'b1;
          err_x    <= s3_x;
          err_y    <= s3_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_isqrt_check_pipe.sv
// -----------------------------------------------------------------------------
// tb_isqrt_check_pipe
//
// Self-checking bench for isqrt_check_pipe. Two instances share all inputs:
// the default configuration (W=32, CNT_W=16) and a narrow-counter one
// (CNT_W=4) used to observe saturation. Expected values come from a
// cycle-indexed history of accepted pairs and a reference floor(sqrt(x))
// computed by bitwise search.
// -----------------------------------------------------------------------------
module tb_isqrt_check_pipe;

  localparam int W    = 32;
  localparam int HMAX = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arg_vld = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;

  logic        res_vld, res_ok, err_seen;
  logic [15:0] chk_cnt, err_cnt;
  logic [31:0] err_x, err_y;

  logic        r4_vld, r4_ok, seen4;
  logic [3:0]  chk4, err4;
  logic [31:0] ex4, ey4;

  isqrt_check_pipe #(.W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .x(x), .y(y), .clr(clr),
    .res_vld(res_vld), .res_ok(res_ok), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .err_seen(err_seen), .err_x(err_x), .err_y(err_y)
  );

  isqrt_check_pipe #(.W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .x(x), .y(y), .clr(clr),
    .res_vld(r4_vld), .res_ok(r4_ok), .chk_cnt(chk4), .err_cnt(err4),
    .err_seen(seen4), .err_x(ex4), .err_y(ey4)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          e        = 0;   // index of the last clock edge
  int          flush    = 0;   // pairs captured at edges <= flush were dropped
  bit          h_vld [0:HMAX-1];
  bit          h_ok  [0:HMAX-1];
  logic [31:0] h_x   [0:HMAX-1];
  logic [31:0] h_y   [0:HMAX-1];

  bit          m_vld, m_ok, m_seen;
  logic [15:0] m_chk, m_err;
  logic [3:0]  m_chk4, m_err4;
  logic [31:0] m_ex, m_ey;

  function automatic logic [31:0] ref_isqrt(input logic [31:0] v);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if ({32'd0, t} * {32'd0, t} <= {32'd0, v}) r = t;
    end
    return r;
  endfunction

  task automatic model_clear_stats();
    m_chk = '0; m_err = '0; m_chk4 = '0; m_err4 = '0;
    m_seen = 1'b0; m_ex = '0; m_ey = '0;
  endtask

  task automatic model_reset();
    flush = e;
    m_vld = 1'b0;
    m_ok  = 1'b0;
    model_clear_stats();
  endtask

  // Advance one clock and update the model with what the DUT saw at the edge.
  task automatic tick();
    bit          v, c, r;
    logic [31:0] tx, ty;
    int          rs, st;
    v = arg_vld; c = clr; r = rst; tx = x; ty = y;
    @(posedge clk);
    #1;
    e++;
    if (e >= HMAX - 1) begin
      $display("FAIL history_bound: edge %0d reached limit %0d", e, HMAX);
      $fatal(1, "history overflow");
    end
    if (!r) begin
      h_vld[e] = 1'b0;
      model_reset();
    end else begin
      h_vld[e] = v;
      h_ok[e]  = (ty == ref_isqrt(tx));
      h_x[e]   = tx;
      h_y[e]   = ty;
      rs = e - 2;
      if (rs > flush && h_vld[rs]) begin
        m_vld = 1'b1;
        m_ok  = h_ok[rs];
      end else begin
        m_vld = 1'b0;
      end
      st = e - 3;
      if (c) begin
        model_clear_stats();
      end else if (st > flush && h_vld[st]) begin
        if (m_chk != 16'hFFFF) m_chk++;
        if (m_chk4 != 4'hF) m_chk4++;
        if (!h_ok[st]) begin
          if (m_err != 16'hFFFF) m_err++;
          if (m_err4 != 4'hF) m_err4++;
          if (!m_seen) begin
            m_seen = 1'b1;
            m_ex   = h_x[st];
            m_ey   = h_y[st];
          end
        end
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] dx, input logic [31:0] dy);
    arg_vld = v; x = dx; y = dy;
  endtask

  task automatic clr_pulse();
    drive(1'b0, $urandom, $urandom);
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #3 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(i % 2 == 0, $urandom, $urandom);
      tick();
      n_checks++;
      if (res_vld !== 1'b0) begin n_fail++; $display("FAIL reset res_vld: got %b want 0", res_vld); end
      n_checks++;
      if (chk_cnt !== 16'd0 || err_cnt !== 16'd0) begin
        n_fail++; $display("FAIL reset counters: got chk=%0d err=%0d want 0/0", chk_cnt, err_cnt);
      end
      n_checks++;
      if (err_seen !== 1'b0 || res_ok !== 1'b0) begin
        n_fail++; $display("FAIL reset flags: got err_seen=%b res_ok=%b want 0/0", err_seen, res_ok);
      end
    end
    rst = 1'b1;
    // Pairs presented right after release must still take the full latency.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'd4, 32'd2);
      tick();
      n_checks++;
      if (res_vld !== m_vld) begin
        n_fail++; $display("FAIL post_reset res_vld t%0d: got %b want %b", i, res_vld, m_vld);
      end
    end
    drive(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_stream();
    logic [31:0] px [6] = '{32'd0, 32'd1, 32'd3, 32'd4, 32'd15, 32'd16};
    logic [31:0] py [6] = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd3,  32'd4};
    int first_hi, n_hi;
    first_hi = -1; n_hi = 0;
    clr_pulse();
    for (int t = 1; t <= 12; t++) begin
      if (t <= 6) drive(1'b1, px[t-1], py[t-1]);
      else        drive(1'b0, $urandom, $urandom);
      tick();
      if (res_vld === 1'b1) begin
        n_hi++;
        if (first_hi < 0) first_hi = t;
      end
      n_checks++;
      if (res_vld !== m_vld || res_ok !== m_ok) begin
        n_fail++; $display("FAIL stream result t%0d: got vld=%b ok=%b want vld=%b ok=%b", t, res_vld, res_ok, m_vld, m_ok);
      end
      n_checks++;
      if (chk_cnt !== m_chk || err_cnt !== m_err) begin
        n_fail++; $display("FAIL stream counters t%0d: got %0d/%0d want %0d/%0d", t, chk_cnt, err_cnt, m_chk, m_err);
      end
    end
    n_checks++;
    if (first_hi != 3 || n_hi != 6) begin
      n_fail++; $display("FAIL stream window: got first=%0d count=%0d want first=3 count=6", first_hi, n_hi);
    end
    n_checks++;
    if (chk_cnt !== 16'd6 || err_cnt !== 16'd0 || err_seen !== 1'b0) begin
      n_fail++; $display("FAIL stream totals: got chk=%0d err=%0d seen=%b want 6/0/0", chk_cnt, err_cnt, err_seen);
    end
  endtask

  task automatic test_bounds();
    logic [31:0] px [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd8, 32'd9};
    logic [31:0] py [5] = '{32'h0000_FFFF, 32'h0001_0000, 32'hFFFF_FFFF, 32'd3, 32'd2};
    bit          want [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    clr_pulse();
    for (int t = 1; t <= 11; t++) begin
      if (t <= 5) drive(1'b1, px[t-1], py[t-1]);
      else        drive(1'b0, $urandom, $urandom);
      tick();
      if (t >= 3 && t <= 7) begin
        n_checks++;
        if (res_vld !== 1'b1 || res_ok !== want[t-3]) begin
          n_fail++; $display("FAIL bounds pair%0d: got vld=%b ok=%b want 1/%b", t - 3, res_vld, res_ok, want[t-3]);
        end
      end
      n_checks++;
      if (err_cnt !== m_err || err_seen !== m_seen) begin
        n_fail++; $display("FAIL bounds stats t%0d: got err=%0d seen=%b want %0d/%b", t, err_cnt, err_seen, m_err, m_seen);
      end
    end
    n_checks++;
    if (err_cnt !== 16'd4 || chk_cnt !== 16'd5) begin
      n_fail++; $display("FAIL bounds totals: got chk=%0d err=%0d want 5/4", chk_cnt, err_cnt);
    end
    n_checks++;
    if (err_x !== 32'hFFFF_FFFF || err_y !== 32'h0001_0000 || err_seen !== 1'b1) begin
      n_fail++; $display("FAIL bounds capture: got x=%h y=%h seen=%b want ffffffff/00010000/1", err_x, err_y, err_seen);
    end
  endtask

  task automatic test_gaps();
    bit          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    bit          obs [16];
    logic [31:0] a1x, a1y, a2x, a2y;
    logic [63:0] a2sq;
    logic [64:0] a2p;
    bit          v, a1v;
    logic [31:0] rx;
    for (int t = 1; t <= 12; t++) begin
      rx = $urandom;
      v  = (t <= 6) ? pat[t-1] : 1'b0;
      drive(v, rx, ($urandom_range(0, 1) == 1) ? ref_isqrt(rx) : $urandom);
      a1x = dut.s1_x; a1y = dut.s1_y; a1v = dut.s1_vld;
      a2x = dut.s2_x; a2y = dut.s2_y; a2sq = dut.s2_sq; a2p = dut.s2_p;
      tick();
      obs[t] = res_vld;
      if (!v) begin
        n_checks++;
        if (dut.s1_x !== a1x || dut.s1_y !== a1y) begin
          n_fail++; $display("FAIL gaps s1_hold t%0d: got %h/%h want %h/%h", t, dut.s1_x, dut.s1_y, a1x, a1y);
        end
      end
      if (!a1v) begin
        n_checks++;
        if (dut.s2_x !== a2x || dut.s2_y !== a2y || dut.s2_sq !== a2sq || dut.s2_p !== a2p) begin
          n_fail++; $display("FAIL gaps s2_hold t%0d: got x=%h y=%h want x=%h y=%h", t, dut.s2_x, dut.s2_y, a2x, a2y);
        end
      end
      n_checks++;
      if (res_vld !== m_vld || res_ok !== m_ok) begin
        n_fail++; $display("FAIL gaps result t%0d: got vld=%b ok=%b want vld=%b ok=%b", t, res_vld, res_ok, m_vld, m_ok);
      end
    end
    for (int k = 1; k <= 6; k++) begin
      n_checks++;
      if (obs[k+2] !== pat[k-1]) begin
        n_fail++; $display("FAIL gaps pattern k%0d: got %b want %b", k, obs[k+2], pat[k-1]);
      end
    end
  endtask

  task automatic test_clr();
    clr_pulse();
    drive(1'b1, 32'd9, 32'd2); tick();     // t1: fails, counted
    drive(1'b1, 32'd8, 32'd3); tick();     // t2: fails, its update meets clr
    drive(1'b0, '0, '0);       tick();     // t3
    tick();                                // t4: first failure counted
    n_checks++;
    if (err_cnt !== 16'd1 || err_seen !== 1'b1 || err_x !== 32'd9 || err_y !== 32'd2) begin
      n_fail++; $display("FAIL clr before: got err=%0d seen=%b x=%0d y=%0d want 1/1/9/2", err_cnt, err_seen, err_x, err_y);
    end
    clr = 1'b1; tick(); clr = 1'b0;       // t5: second result's update cycle
    n_checks++;
    if (err_cnt !== 16'd0 || chk_cnt !== 16'd0 || err_seen !== 1'b0 || err_x !== 32'd0 || err_y !== 32'd0) begin
      n_fail++; $display("FAIL clr cleared: got chk=%0d err=%0d seen=%b x=%h y=%h want all 0", chk_cnt, err_cnt, err_seen, err_x, err_y);
    end
    n_checks++;
    if (m_err !== err_cnt || m_seen !== err_seen) begin
      n_fail++; $display("FAIL clr model: got err=%0d seen=%b want %0d/%b", err_cnt, err_seen, m_err, m_seen);
    end
    drive(1'b1, 32'd5, 32'd1); tick();
    drive(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) tick();
    n_checks++;
    if (err_cnt !== 16'd1 || chk_cnt !== 16'd1 || err_x !== 32'd5 || err_y !== 32'd1 || err_seen !== 1'b1) begin
      n_fail++; $display("FAIL clr recapture: got chk=%0d err=%0d x=%0d y=%0d want 1/1/5/1", chk_cnt, err_cnt, err_x, err_y);
    end
  endtask

  task automatic test_random();
    logic [31:0] rx, ry;
    int          kind;
    for (int t = 0; t < 80; t++) begin
      rx   = $urandom;
      kind = $urandom_range(0, 4);
      case (kind)
        0:       ry = ref_isqrt(rx);
        1:       ry = ref_isqrt(rx) + 32'd1;
        2:       ry = ref_isqrt(rx) - 32'd1;
        3:       begin rx = rx & 32'h0000_03FF; ry = ref_isqrt(rx); end
        default: ry = $urandom;
      endcase
      drive(t < 74 && $urandom_range(0, 3) != 0, rx, ry);
      tick();
      n_checks++;
      if (res_vld !== m_vld || res_ok !== m_ok) begin
        n_fail++; $display("FAIL random result t%0d: got vld=%b ok=%b want vld=%b ok=%b", t, res_vld, res_ok, m_vld, m_ok);
      end
      n_checks++;
      if (chk_cnt !== m_chk || err_cnt !== m_err || err_seen !== m_seen) begin
        n_fail++; $display("FAIL random stats t%0d: got %0d/%0d/%b want %0d/%0d/%b", t, chk_cnt, err_cnt, err_seen, m_chk, m_err, m_seen);
      end
      n_checks++;
      if (err_x !== m_ex || err_y !== m_ey) begin
        n_fail++; $display("FAIL random capture t%0d: got %h/%h want %h/%h", t, err_x, err_y, m_ex, m_ey);
      end
    end
  endtask

  task automatic test_sat();
    logic [31:0] rx;
    clr_pulse();
    for (int t = 0; t < 28; t++) begin
      rx = $urandom;
      if (t < 20) drive(1'b1, rx, ref_isqrt(rx) + 32'd1);
      else        drive(1'b0, rx, '0);
      tick();
      n_checks++;
      if (chk4 !== m_chk4 || err4 !== m_err4) begin
        n_fail++; $display("FAIL sat narrow t%0d: got %0d/%0d want %0d/%0d", t, chk4, err4, m_chk4, m_err4);
      end
    end
    n_checks++;
    if (chk4 !== 4'hF || err4 !== 4'hF || chk_cnt !== 16'd20 || err_cnt !== 16'd20) begin
      n_fail++; $display("FAIL sat totals: got n4=%0d/%0d n16=%0d/%0d want 15/15 20/20", chk4, err4, chk_cnt, err_cnt);
    end
    for (int t = 0; t < 3; t++) begin
      rx = $urandom; drive(1'b1, rx, ref_isqrt(rx) + 32'd2); tick();
    end
    drive(1'b0, '0, '0);
    for (int t = 0; t < 4; t++) tick();
    n_checks++;
    if (chk4 !== 4'hF || err4 !== 4'hF || chk_cnt !== 16'd23) begin
      n_fail++; $display("FAIL sat hold: got n4=%0d/%0d chk16=%0d want 15/15 23", chk4, err4, chk_cnt);
    end
    // Async reset with pairs in flight.
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 32'd7, 32'd1); tick();
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (res_vld !== 1'b0 || res_ok !== 1'b0 || chk_cnt !== 16'd0 || err_cnt !== 16'd0 ||
        err_seen !== 1'b0 || err_x !== 32'd0 || err_y !== 32'd0) begin
      n_fail++; $display("FAIL sat async_rst: got vld=%b chk=%0d err=%0d seen=%b x=%h", res_vld, chk_cnt, err_cnt, err_seen, err_x);
    end
    n_checks++;
    if (r4_vld !== 1'b0 || chk4 !== 4'd0 || err4 !== 4'd0 || seen4 !== 1'b0 || ex4 !== 32'd0 || ey4 !== 32'd0) begin
      n_fail++; $display("FAIL sat async_rst4: got vld=%b chk=%0d err=%0d seen=%b", r4_vld, chk4, err4, seen4);
    end
    drive(1'b0, '0, '0);
    tick();
    rst = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_checks++;
      if (res_vld !== 1'b0 || r4_vld !== 1'b0 || chk_cnt !== m_chk) begin
        n_fail++; $display("FAIL sat flushed t%0d: got vld=%b/%b chk=%0d want 0/0/%0d", t, res_vld, r4_vld, chk_cnt, m_chk);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < HMAX; i++) begin
      h_vld[i] = 1'b0; h_ok[i] = 1'b0; h_x[i] = '0; h_y[i] = '0;
    end
    model_reset();
    test_reset();
    test_stream();
    test_bounds();
    test_gaps();
    test_clr();
    test_random();
    test_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
